axil_csr_arbiter: RTL and testbench

- Shares one AXI-Lite slave port, typically the CSR block, between MASTERS AXI-Lite requesters, e.g. host bridge, debug UART and init sequencer.
- Exactly one transaction (read or write) is in flight at a time. Arbitration is round-robin across masters.
- Sits between the requesters and the CSR slave. Adds one arbitration cycle per transaction and no data buffering.

---
 rtl/axil_pkg.sv | 17 +
 rtl/rr_picker.sv | 32 +++
 rtl/axil_csr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_axil_csr_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the CSR arbiter slice.
// Holds the arbiter state encoding and AXI-Lite response and prot constants.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RDATA
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Searches upward from ptr+1, wrapping, and returns the first requester.
module rr_picker #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] sel,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] cand;

    always_comb begin
        sel  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // k = N wraps back to ptr itself, so it is checked last
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                sel[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/axil_csr_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite slave among several masters.
// One transaction in flight; writes win over reads within a master.
module axil_csr_arbiter
    import axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MASTERS = 2,
    localparam int GW     = $clog2(MASTERS)
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [MASTERS-1:0][ADDR_W-1:0] mAwAddr,
    input  logic [MASTERS-1:0][2:0]        mAwProt,
    input  logic [MASTERS-1:0]             mAwValid,
    output logic [MASTERS-1:0]             mAwReady,
    input  logic [MASTERS-1:0][31:0]       mWData,
    input  logic [MASTERS-1:0][3:0]        mWStrb,
    input  logic [MASTERS-1:0]             mWValid,
    output logic [MASTERS-1:0]             mWReady,
    output logic [MASTERS-1:0][1:0]        mBResp,
    output logic [MASTERS-1:0]             mBValid,
    input  logic [MASTERS-1:0]             mBReady,
    input  logic [MASTERS-1:0][ADDR_W-1:0] mArAddr,
    input  logic [MASTERS-1:0][2:0]        mArProt,
    input  logic [MASTERS-1:0]             mArValid,
    output logic [MASTERS-1:0]             mArReady,
    output logic [MASTERS-1:0][31:0]       mRData,
    output logic [MASTERS-1:0][1:0]        mRResp,
    output logic [MASTERS-1:0]             mRValid,
    input  logic [MASTERS-1:0]             mRReady,
    output logic [ADDR_W-1:0]              sAwAddr,
    output logic [2:0]                     sAwProt,
    output logic                           sAwValid,
    input  logic                           sAwReady,
    output logic [31:0]                    sWData,
    output logic [3:0]                     sWStrb,
    output logic                           sWValid,
    input  logic                           sWReady,
    input  logic [1:0]                     sBResp,
    input  logic                           sBValid,
    output logic                           sBReady,
    output logic [ADDR_W-1:0]              sArAddr,
    output logic [2:0]                     sArProt,
    output logic                           sArValid,
    input  logic                           sArReady,
    input  logic [31:0]                    sRData,
    input  logic [1:0]                     sRResp,
    input  logic                           sRValid,
    output logic                           sRReady,
    output logic [GW-1:0]                  grant,
    output logic                           busy
);

    arb_state_e state, stateNext;
    logic [GW-1:0] ptr, ptrNext, grantNext, pick;
    logic [MASTERS-1:0] wrReq, req, sel;
    logic anyReq;
    logic awDone, awDoneNext, wDone, wDoneNext;

    assign wrReq = mAwValid & mWValid;
    assign req   = wrReq | mArValid;
    assign busy  = (state != IDLE);

    rr_picker #(.N(MASTERS), .W(GW)) u_pick (
        .req (req),
        .ptr (ptr),
        .sel (sel),
        .idx (pick),
        .any (anyReq)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state  <= IDLE;
            grant  <= '0;
            ptr    <= '0;
            awDone <= 1'b0;
            wDone  <= 1'b0;
        end else begin
            state  <= stateNext;
            grant  <= grantNext;
            ptr    <= ptrNext;
            awDone <= awDoneNext;
            wDone  <= wDoneNext;
        end
    end

    always_comb begin
        stateNext  = state;
        grantNext  = grant;
        ptrNext    = ptr;
        awDoneNext = awDone;
        wDoneNext  = wDone;
        mAwReady   = '0;
        mWReady    = '0;
        mBResp     = '0;
        mBValid    = '0;
        mArReady   = '0;
        mRData     = '0;
        mRResp     = '0;
        mRValid    = '0;
        sAwAddr    = '0;
        sAwProt    = PROT_DEFAULT;
        sAwValid   = 1'b0;
        sWData     = '0;
        sWStrb     = '0;
        sWValid    = 1'b0;
        sBReady    = 1'b0;
        sArAddr    = '0;
        sArProt    = PROT_DEFAULT;
        sArValid   = 1'b0;
        sRReady    = 1'b0;
        unique case (state)
            IDLE: begin
                awDoneNext = 1'b0;
                wDoneNext  = 1'b0;
                if (anyReq) begin
                    grantNext = pick;
                    stateNext = (|(wrReq & sel)) ? WR : RD;
                end
            end
            WR: begin
                // AW and W retire independently; each valid drops once its handshake is done
                if (!awDone) begin
                    sAwValid        = 1'b1;
                    sAwAddr         = mAwAddr[grant];
                    sAwProt         = mAwProt[grant];
                    mAwReady[grant] = sAwReady;
                end
                if (!wDone) begin
                    sWValid        = 1'b1;
                    sWData         = mWData[grant];
                    sWStrb         = mWStrb[grant];
                    mWReady[grant] = sWReady;
                end
                awDoneNext = awDone | sAwReady;
                wDoneNext  = wDone | sWReady;
                if (awDoneNext && wDoneNext) begin
                    stateNext = WRESP;
                end
            end
            WRESP: begin
                sBReady        = mBReady[grant];
                mBValid[grant] = sBValid;
                mBResp[grant]  = sBResp;
                if (sBValid && mBReady[grant]) begin
                    ptrNext   = grant;
                    stateNext = IDLE;
                end
            end
            RD: begin
                sArValid        = 1'b1;
                sArAddr         = mArAddr[grant];
                sArProt         = mArProt[grant];
                mArReady[grant] = sArReady;
                if (sArReady) begin
                    stateNext = RDATA;
                end
            end
            RDATA: begin
                sRReady        = mRReady[grant];
                mRValid[grant] = sRValid;
                mRData[grant]  = sRData;
                mRResp[grant]  = sRResp;
                if (sRValid && mRReady[grant]) begin
                    ptrNext   = grant;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_csr_arbiter.sv
// Scenario bench for axil_csr_arbiter with a reactive slave model.
// Expected master-side responses are queued at stimulus time and popped on delivery.
module tb_axil_csr_arbiter;
    import axil_pkg::*;

    localparam int AW = 32;
    localparam int NM = 2;

    typedef struct packed {
        logic        wr;
        logic [2:0]  m;
        logic [31:0] data;
        logic [1:0]  resp;
    } txn_t;

    logic aclk = 1'b0;
    logic areset;
    logic [NM-1:0][AW-1:0] mAwAddr, mArAddr;
    logic [NM-1:0][2:0] mAwProt, mArProt;
    logic [NM-1:0][31:0] mWData, mRData;
    logic [NM-1:0][3:0] mWStrb;
    logic [NM-1:0][1:0] mBResp, mRResp;
    logic [NM-1:0] mAwValid, mAwReady, mWValid, mWReady, mBValid, mBReady;
    logic [NM-1:0] mArValid, mArReady, mRValid, mRReady;
    logic [AW-1:0] sAwAddr, sArAddr;
    logic [2:0] sAwProt, sArProt;
    logic [31:0] sWData, sRData;
    logic [3:0] sWStrb;
    logic [1:0] sBResp, sRResp;
    logic sAwValid, sAwReady, sWValid, sWReady, sBValid, sBReady;
    logic sArValid, sArReady, sRValid, sRReady;
    logic [0:0] grant;
    logic busy;

    txn_t expq[$];
    txn_t obs[$];
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mem [16];
    bit awHave, wHave;
    logic [31:0] awA, wD;
    logic [3:0] wS;

    always #5 aclk = ~aclk;

    axil_csr_arbiter #(.ADDR_W(AW), .MASTERS(NM)) dut (
        .aclk(aclk), .areset(areset),
        .mAwAddr(mAwAddr), .mAwProt(mAwProt), .mAwValid(mAwValid), .mAwReady(mAwReady),
        .mWData(mWData), .mWStrb(mWStrb), .mWValid(mWValid), .mWReady(mWReady),
        .mBResp(mBResp), .mBValid(mBValid), .mBReady(mBReady),
        .mArAddr(mArAddr), .mArProt(mArProt), .mArValid(mArValid), .mArReady(mArReady),
        .mRData(mRData), .mRResp(mRResp), .mRValid(mRValid), .mRReady(mRReady),
        .sAwAddr(sAwAddr), .sAwProt(sAwProt), .sAwValid(sAwValid), .sAwReady(sAwReady),
        .sWData(sWData), .sWStrb(sWStrb), .sWValid(sWValid), .sWReady(sWReady),
        .sBResp(sBResp), .sBValid(sBValid), .sBReady(sBReady),
        .sArAddr(sArAddr), .sArProt(sArProt), .sArValid(sArValid), .sArReady(sArReady),
        .sRData(sRData), .sRResp(sRResp), .sRValid(sRValid), .sRReady(sRReady),
        .grant(grant), .busy(busy)
    );

    task automatic slave_clear();
        sBValid = 1'b0;
        sRValid = 1'b0;
        sBResp  = '0;
        sRResp  = '0;
        sRData  = '0;
        awHave  = 1'b0;
        wHave   = 1'b0;
    endtask

    // One clock: sample handshakes at negedge, react just after posedge
    task automatic tick();
        bit aF, wF, bF, arF, rF;
        logic [31:0] aA, dW, arA;
        logic [3:0] sW;
        logic [NM-1:0] maw, mw, mar;
        txn_t t;
        @(negedge aclk);
        aF = sAwValid && sAwReady; aA = sAwAddr;
        wF = sWValid && sWReady; dW = sWData; sW = sWStrb;
        bF = sBValid && sBReady;
        arF = sArValid && sArReady; arA = sArAddr;
        rF = sRValid && sRReady;
        maw = mAwValid & mAwReady;
        mw = mWValid & mWReady;
        mar = mArValid & mArReady;
        for (int i = 0; i < NM; i++) begin
            if (mBValid[i] && mBReady[i]) begin
                t = '{wr: 1'b1, m: 3'(i), data: 32'h0, resp: mBResp[i]};
                obs.push_back(t);
            end
            if (mRValid[i] && mRReady[i]) begin
                t = '{wr: 1'b0, m: 3'(i), data: mRData[i], resp: mRResp[i]};
                obs.push_back(t);
            end
        end
        @(posedge aclk);
        #1;
        mAwValid = mAwValid & ~maw;
        mWValid  = mWValid & ~mw;
        mArValid = mArValid & ~mar;
        if (bF) sBValid = 1'b0;
        if (rF) sRValid = 1'b0;
        if (aF) begin awHave = 1'b1; awA = aA; end
        if (wF) begin wHave = 1'b1; wD = dW; wS = sW; end
        if (awHave && wHave) begin
            sBResp = (awA >= 32'h40) ? RESP_SLVERR : RESP_OKAY;
            if (awA < 32'h40) begin
                for (int b = 0; b < 4; b++)
                    if (wS[b]) mem[awA[5:2]][8*b +: 8] = wD[8*b +: 8];
            end
            sBValid = 1'b1;
            awHave = 1'b0;
            wHave = 1'b0;
        end
        if (arF) begin
            sRValid = 1'b1;
            sRData = (arA >= 32'h40) ? 32'h0 : mem[arA[5:2]];
            sRResp = (arA >= 32'h40) ? RESP_SLVERR : RESP_OKAY;
        end
        #1;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && obs.size() < n; c++) tick();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        slave_clear();
        obs.delete();
        expq.delete();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        slave_clear();
        #1;
        vectors++;
        if ({mAwReady, mWReady, mBValid, mArReady, mRValid, sAwValid, sWValid,
             sArValid, sBReady, sRReady} !== '0) begin
            miscompares++;
            $display("FAIL reset_hs: valids/readies not all 0");
        end
        vectors++;
        if (busy !== 1'b0 || grant !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b grant=%0d, required 0 0", busy, grant);
        end
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        tick();
        vectors++;
        if (busy !== 1'b0 || sAwValid !== 1'b0 || sArValid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single_write();
        txn_t e, t;
        mAwAddr[0] = 32'h4; mAwProt[0] = 3'b010;
        mWData[0] = 32'hDEADBEEF; mWStrb[0] = 4'hF;
        mAwValid[0] = 1'b1; mWValid[0] = 1'b1;
        expq.push_back('{wr: 1'b1, m: 3'd0, data: 32'h0, resp: RESP_OKAY});
        #1;
        vectors++;
        if (sAwValid !== 1'b0 || sWValid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_arb_cycle: sAwValid=%b sWValid=%b, required 0 0", sAwValid, sWValid);
        end
        tick();
        vectors++;
        if (sAwValid !== 1'b1 || sWValid !== 1'b1 || sAwAddr !== 32'h4
            || sWData !== 32'hDEADBEEF || sWStrb !== 4'hF || sAwProt !== 3'b010) begin
            miscompares++;
            $display("FAIL wr_slave_drive: addr=%h data=%h v=%b%b, required 4 deadbeef 11",
                     sAwAddr, sWData, sAwValid, sWValid);
        end
        vectors++;
        if (grant !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_grant: grant=%0d busy=%b, required 0 1", grant, busy);
        end
        run_until(1, 20);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            if (obs.size() == 0) begin
                miscompares++;
                $display("FAIL wr_resp: none, required %h", e);
            end else begin
                t = obs.pop_front();
                if (t !== e) begin
                    miscompares++;
                    $display("FAIL wr_resp: got %h, required %h", t, e);
                end
            end
        end
    endtask

    task automatic test_concurrent_reads();
        txn_t e, t;
        int phase, gap;
        logic firstGrant;
        do_reset();
        mem[0] = 32'h1111_0000;
        mem[2] = 32'h2222_0008;
        mArAddr[0] = 32'h0; mArAddr[1] = 32'h8;
        mArProt[0] = 3'b001; mArProt[1] = 3'b001;
        mArValid = 2'b11;
        expq.push_back('{wr: 1'b0, m: 3'd1, data: 32'h2222_0008, resp: RESP_OKAY});
        expq.push_back('{wr: 1'b0, m: 3'd0, data: 32'h1111_0000, resp: RESP_OKAY});
        phase = 0; gap = 0; firstGrant = 1'bx;
        for (int c = 0; c < 40 && obs.size() < 2; c++) begin
            tick();
            if (phase == 0 && busy) begin
                phase = 1; firstGrant = grant;
            end else if (phase == 1 && !busy) begin
                phase = 2; gap = 1;
            end else if (phase == 2) begin
                if (busy) phase = 3;
                else gap++;
            end
        end
        vectors++;
        if (firstGrant !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_first: grant=%0d, required 1", firstGrant);
        end
        vectors++;
        if (phase != 3 || gap != 1) begin
            miscompares++;
            $display("FAIL rr_gap: idle cycles=%0d phase=%0d, required 1 3", gap, phase);
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            if (obs.size() == 0) begin
                miscompares++;
                $display("FAIL rr_rdata: none, required %h", e);
            end else begin
                t = obs.pop_front();
                if (t !== e) begin
                    miscompares++;
                    $display("FAIL rr_rdata: got %h, required %h", t, e);
                end
            end
        end
    endtask

    task automatic test_write_then_read();
        txn_t e, t;
        bit early;
        mem[4] = 32'hA000_0004;
        mAwAddr[1] = 32'h10; mAwProt[1] = 3'b000;
        mWData[1] = 32'h1234_5678; mWStrb[1] = 4'b0011;
        mArAddr[1] = 32'h10;
        mAwValid[1] = 1'b1; mWValid[1] = 1'b1; mArValid[1] = 1'b1;
        expq.push_back('{wr: 1'b1, m: 3'd1, data: 32'h0, resp: RESP_OKAY});
        expq.push_back('{wr: 1'b0, m: 3'd1, data: 32'hA000_5678, resp: RESP_OKAY});
        early = 1'b0;
        for (int c = 0; c < 40 && obs.size() < 2; c++) begin
            tick();
            if (sArValid && obs.size() == 0) early = 1'b1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL wr_first: sArValid rose before B, required after");
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            if (obs.size() == 0) begin
                miscompares++;
                $display("FAIL wr_then_rd: none, required %h", e);
            end else begin
                t = obs.pop_front();
                if (t !== e) begin
                    miscompares++;
                    $display("FAIL wr_then_rd: got %h, required %h", t, e);
                end
            end
        end
    endtask

    task automatic test_w_before_aw();
        txn_t e, t;
        sAwReady = 1'b0;
        sWReady = 1'b1;
        mAwAddr[0] = 32'h8; mWData[0] = 32'hCAFE_F00D; mWStrb[0] = 4'hF;
        mAwValid[0] = 1'b1; mWValid[0] = 1'b1;
        expq.push_back('{wr: 1'b1, m: 3'd0, data: 32'h0, resp: RESP_OKAY});
        tick();
        vectors++;
        if (sAwValid !== 1'b1 || sWValid !== 1'b1) begin
            miscompares++;
            $display("FAIL split_start: v=%b%b, required 11", sAwValid, sWValid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (sWValid !== 1'b0 || sAwValid !== 1'b1 || sBReady !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL split_wait: c=%0d aw=%b w=%b bRdy=%b, required 1 0 0",
                         c, sAwValid, sWValid, sBReady);
            end
        end
        sAwReady = 1'b1;
        #1;
        vectors++;
        if (mAwReady !== 2'b01 || mWReady !== 2'b00) begin
            miscompares++;
            $display("FAIL split_ready: aw=%b w=%b, required 01 00", mAwReady, mWReady);
        end
        tick();
        vectors++;
        if (sAwValid !== 1'b0 || sBValid !== 1'b1 || sBReady !== 1'b1) begin
            miscompares++;
            $display("FAIL split_wresp: aw=%b bv=%b br=%b, required 0 1 1",
                     sAwValid, sBValid, sBReady);
        end
        run_until(1, 20);
        vectors++;
        if (mem[2] !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL split_data: mem=%h, required cafef00d", mem[2]);
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            if (obs.size() == 0) begin
                miscompares++;
                $display("FAIL split_b: none, required %h", e);
            end else begin
                t = obs.pop_front();
                if (t !== e) begin
                    miscompares++;
                    $display("FAIL split_b: got %h, required %h", t, e);
                end
            end
        end
    endtask

    task automatic test_rready_stall();
        txn_t e, t;
        mem[0] = 32'h3333_0000;
        mem[3] = 32'h4444_000C;
        mRReady = 2'b10;
        mArAddr[0] = 32'h0;
        mArValid[0] = 1'b1;
        expq.push_back('{wr: 1'b0, m: 3'd0, data: 32'h3333_0000, resp: RESP_OKAY});
        tick();
        tick();
        mArAddr[1] = 32'hC;
        mArValid[1] = 1'b1;
        expq.push_back('{wr: 1'b0, m: 3'd1, data: 32'h4444_000C, resp: RESP_OKAY});
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (sRReady !== 1'b0 || sArValid !== 1'b0 || mArReady !== 2'b00
                || grant !== 1'b0 || busy !== 1'b1 || sRValid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall: c=%0d rRdy=%b arV=%b grant=%0d busy=%b, required 0 0 0 1",
                         c, sRReady, sArValid, grant, busy);
            end
            tick();
        end
        mRReady = 2'b11;
        run_until(2, 30);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            if (obs.size() == 0) begin
                miscompares++;
                $display("FAIL stall_rdata: none, required %h", e);
            end else begin
                t = obs.pop_front();
                if (t !== e) begin
                    miscompares++;
                    $display("FAIL stall_rdata: got %h, required %h", t, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        txn_t e, t;
        mBReady = 2'b01;
        mAwAddr[1] = 32'h14; mWData[1] = 32'h0BAD_0BAD; mWStrb[1] = 4'hF;
        mAwValid[1] = 1'b1; mWValid[1] = 1'b1;
        tick();
        tick();
        vectors++;
        if (mBValid !== 2'b10 || grant !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_wresp: bv=%b grant=%0d, required 10 1", mBValid, grant);
        end
        areset = 1'b1;
        #1;
        vectors++;
        if ({mAwReady, mWReady, mBValid, mArReady, mRValid, sAwValid, sWValid,
             sArValid, sBReady, sRReady} !== '0 || busy !== 1'b0 || grant !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b grant=%0d sBReady=%b, required all 0",
                     busy, grant, sBReady);
        end
        do_reset();
        mBReady = 2'b11;
        mAwAddr[0] = 32'h80; mWData[0] = 32'h0000_0055; mWStrb[0] = 4'hF;
        mAwValid[0] = 1'b1; mWValid[0] = 1'b1;
        expq.push_back('{wr: 1'b1, m: 3'd0, data: 32'h0, resp: RESP_SLVERR});
        run_until(1, 20);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            if (obs.size() == 0) begin
                miscompares++;
                $display("FAIL post_reset_wr: none, required %h", e);
            end else begin
                t = obs.pop_front();
                if (t !== e) begin
                    miscompares++;
                    $display("FAIL post_reset_wr: got %h, required %h", t, e);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        mAwAddr = '0; mAwProt = '0; mAwValid = '0;
        mWData = '0; mWStrb = '0; mWValid = '0;
        mArAddr = '0; mArProt = '0; mArValid = '0;
        mBReady = '1; mRReady = '1;
        sAwReady = 1'b1; sWReady = 1'b1; sArReady = 1'b1;
        awA = '0; wD = '0; wS = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(4 * i);
        slave_clear();
        test_reset();
        test_single_write();
        test_concurrent_reads();
        test_write_then_read();
        test_w_before_aw();
        test_rready_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
